// File: rtl/map_move_rmw.sv
// Read-modify-write engine for map RAM port b: each move writes fill_code into the
// vacated cell and obj_code into the destination, and reports the destination's prior code.
module map_move_rmw #(
  parameter int RD_LAT = 2,
  parameter int COLS   = 40,
  parameter int ROWS   = 30
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          old_x,
  input  logic [4:0]          old_y,
  input  logic [5:0]          new_x,
  input  logic [4:0]          new_y,
  input  logic [3:0]          obj_code,
  input  logic [3:0]          fill_code,
  output logic [4:0]          wraddr,
  output logic                wren,
  output logic [4*COLS-1:0]   wrdata,
  input  logic [4*COLS-1:0]   redata,
  output logic                done,
  output logic [3:0]          hit_code,
  output logic                err
);

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int AW = $clog2(4 * COLS);

  typedef enum logic [2:0] {IDLE, RD_A, WR_A, RD_B, WR_B, FIN} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt;
  logic [5:0]          ox, nx;
  logic [4:0]          ny;
  logic [3:0]          obj, fill;
  logic                same_row;
  logic [3:0]          hit_cand;
  logic [4*COLS-1:0]   merged;
  logic                accept, out_of_range, rd_done;

  // Column 0 sits in the most significant nibble of the row word.
  function automatic logic [AW-1:0] cell_lsb(input logic [5:0] x);
    return AW'(4 * (COLS - 1 - int'(x)));
  endfunction

  function automatic logic [4*COLS-1:0] put_cell(input logic [4*COLS-1:0] w,
                                                 input logic [5:0] x,
                                                 input logic [3:0] c);
    logic [4*COLS-1:0] r;
    r = w;
    r[cell_lsb(x) +: 4] = c;
    return r;
  endfunction

  function automatic logic [3:0] get_cell(input logic [4*COLS-1:0] w, input logic [5:0] x);
    return w[cell_lsb(x) +: 4];
  endfunction

  assign accept       = req_valid & req_ready;
  assign out_of_range = (int'(old_x) >= COLS) || (int'(new_x) >= COLS) ||
                        (int'(old_y) >= ROWS) || (int'(new_y) >= ROWS);
  assign rd_done      = (cnt == CW'(RD_LAT));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = out_of_range ? FIN : RD_A;
      RD_A:    if (rd_done) state_d = WR_A;
      WR_A:    state_d = same_row ? FIN : RD_B;
      RD_B:    if (rd_done) state_d = WR_B;
      WR_B:    state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Same-row moves merge both cells in one pass; obj_code goes last so it wins on old==new.
  always_comb begin
    merged = redata;
    if (state == RD_A) begin
      merged = put_cell(redata, ox, fill);
      if (same_row) merged = put_cell(merged, nx, obj);
    end else begin
      merged = put_cell(redata, nx, obj);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      wren      <= 1'b0;
      wraddr    <= '0;
      wrdata    <= '0;
      done      <= 1'b0;
      hit_code  <= '0;
      err       <= 1'b0;
      hit_cand  <= '0;
      ox        <= '0;
      nx        <= '0;
      ny        <= '0;
      obj       <= '0;
      fill      <= '0;
      same_row  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= ((state == RD_A || state == RD_B) && state_d == state) ? cnt + 1'b1 : '0;
      req_ready <= (state_d == IDLE);
      wren      <= (state_d == WR_A) || (state_d == WR_B);
      done      <= (state_d == FIN);
      // FIN straight out of IDLE only happens for a rejected request.
      err       <= (state_d == FIN) && (state == IDLE);

      if (accept) begin
        ox       <= old_x;
        nx       <= new_x;
        ny       <= new_y;
        obj      <= obj_code;
        fill     <= fill_code;
        same_row <= (old_y == new_y);
        if (!out_of_range) wraddr <= old_y;
      end

      if (state == WR_A && state_d == RD_B) wraddr <= ny;

      if ((state == RD_A || state == RD_B) && rd_done) begin
        wrdata <= merged;
        if (state == RD_B || same_row) hit_cand <= get_cell(redata, nx);
      end

      if (state_d == FIN && state != IDLE) hit_code <= hit_cand;
    end
  end

endmodule

// File: tb/tb_map_move_rmw.sv
// Directed bench for map_move_rmw with a two-cycle-latency map RAM model on port b.
module tb_map_move_rmw;

  logic         clk = 1'b0;
  logic         reset, req_valid, req_ready;
  logic [5:0]   old_x, new_x;
  logic [4:0]   old_y, new_y;
  logic [3:0]   obj_code, fill_code;
  logic [4:0]   wraddr;
  logic         wren;
  logic [159:0] wrdata, redata;
  logic         done, err;
  logic [3:0]   hit_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  map_move_rmw #(.RD_LAT(2), .COLS(40), .ROWS(30)) dut (
    .CLOCK_50(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .obj_code(obj_code), .fill_code(fill_code), .wraddr(wraddr), .wren(wren),
    .wrdata(wrdata), .redata(redata), .done(done), .hit_code(hit_code), .err(err)
  );

  // Map RAM model: address registered, then data registered -> 2 cycles address to data.
  logic [159:0] mem [0:31];
  logic [4:0]   a1;
  logic         pl_en = 1'b0;
  logic [4:0]   pl_addr;
  logic [159:0] pl_data;

  always @(posedge clk) begin
    a1     <= wraddr;
    redata <= mem[a1];
    if (wren) mem[wraddr] <= wrdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  // Event logs sampled on the falling edge.
  int           cyc = 0;
  int           wr_total = 0, done_total = 0, acc_total = 0;
  int           wr_cyc [64];
  logic [4:0]   wr_addr [64];
  logic [159:0] wr_data [64];
  int           done_cyc [64];
  logic [3:0]   done_hit [64];
  logic         done_err [64];
  int           acc_cyc [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren) begin
      wr_cyc[wr_total] = cyc; wr_addr[wr_total] = wraddr; wr_data[wr_total] = wrdata;
      wr_total++;
    end
    if (done) begin
      done_cyc[done_total] = cyc; done_hit[done_total] = hit_code; done_err[done_total] = err;
      done_total++;
    end
    if (req_valid && req_ready) begin
      acc_cyc[acc_total] = cyc;
      acc_total++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] addr, input logic [159:0] data);
    pl_addr = addr; pl_data = data; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  task automatic send(input logic [5:0] ox, input logic [4:0] oy, input logic [5:0] nx,
                      input logic [4:0] ny, input logic [3:0] obj, input logic [3:0] fill,
                      input bit hold, output int t);
    int base;
    base = acc_total;
    old_x = ox; old_y = oy; new_x = nx; new_y = ny; obj_code = obj; fill_code = fill;
    req_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (acc_total > base) break;
    end
    check("accept_seen", 160'(acc_total > base), 160'd1);
    t = acc_cyc[base];
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int n = 0; n < 40; n++) begin
      if (done_total > base) break;
      step();
    end
    check("done_seen", 160'(done_total > base), 160'd1);
  endtask

  int t, wb, db, ab;
  bit ready_busy;

  initial begin
    reset = 1'b1; req_valid = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0; obj_code = '0; fill_code = '0;
    step(); step(); step();
    check("rst_req_ready", 160'(req_ready), 160'd0);
    check("rst_wren",      160'(wren),      160'd0);
    check("rst_wraddr",    160'(wraddr),    160'd0);
    check("rst_wrdata",    wrdata,          160'd0);
    check("rst_done",      160'(done),      160'd0);
    check("rst_hit_code",  160'(hit_code),  160'd0);
    check("rst_err",       160'(err),       160'd0);
    reset = 1'b0;
    step();
    check("post_rst_ready", 160'(req_ready), 160'd1);

    preload(5'd5, {40{4'h1}});
    preload(5'd7, {{10{4'h5}}, 4'h2, {29{4'h5}}});
    preload(5'd8, {{10{4'h6}}, 4'h3, {29{4'h6}}});
    preload(5'd0, {4'h7, 4'h8, {38{4'h9}}});

    // Same-row move (3,5) -> (4,5)
    wb = wr_total; db = done_total;
    send(6'd3, 5'd5, 6'd4, 5'd5, 4'hA, 4'h0, 1'b0, t);
    wait_done(db); step();
    check("t1_wr_count", 160'(wr_total - wb), 160'd1);
    check("t1_wr_lat",   160'(wr_cyc[wb] - t), 160'd4);
    check("t1_wr_addr",  160'(wr_addr[wb]), 160'd5);
    check("t1_wr_data",  wr_data[wb], {12'h111, 4'h0, 4'hA, {35{4'h1}}});
    check("t1_done_lat", 160'(done_cyc[db] - t), 160'd5);
    check("t1_hit",      160'(done_hit[db]), 160'h1);
    check("t1_err",      160'(done_err[db]), 160'd0);

    // Cross-row move (10,7) -> (10,8)
    wb = wr_total; db = done_total;
    send(6'd10, 5'd7, 6'd10, 5'd8, 4'hB, 4'h0, 1'b0, t);
    wait_done(db); step();
    check("t2_wr_count",  160'(wr_total - wb), 160'd2);
    check("t2_wrA_lat",   160'(wr_cyc[wb] - t), 160'd4);
    check("t2_wrA_addr",  160'(wr_addr[wb]), 160'd7);
    check("t2_wrA_data",  wr_data[wb], {{10{4'h5}}, 4'h0, {29{4'h5}}});
    check("t2_wrB_lat",   160'(wr_cyc[wb+1] - t), 160'd8);
    check("t2_wrB_addr",  160'(wr_addr[wb+1]), 160'd8);
    check("t2_wrB_data",  wr_data[wb+1], {{10{4'h6}}, 4'hB, {29{4'h6}}});
    check("t2_done_lat",  160'(done_cyc[db] - t), 160'd9);
    check("t2_hit",       160'(done_hit[db]), 160'h3);
    check("t2_err",       160'(done_err[db]), 160'd0);

    // Same cell (0,0) -> (0,0): obj_code wins
    wb = wr_total; db = done_total;
    send(6'd0, 5'd0, 6'd0, 5'd0, 4'hC, 4'h0, 1'b0, t);
    wait_done(db); step();
    check("t3_wr_count", 160'(wr_total - wb), 160'd1);
    check("t3_wr_data",  wr_data[wb], {4'hC, 4'h8, {38{4'h9}}});
    check("t3_done_lat", 160'(done_cyc[db] - t), 160'd5);
    check("t3_hit",      160'(done_hit[db]), 160'h7);

    // Out of range: new_x = 40, then old_y = 30
    wb = wr_total; db = done_total;
    send(6'd1, 5'd1, 6'd40, 5'd1, 4'hD, 4'h0, 1'b0, t);
    wait_done(db); step();
    check("t4_wr_count", 160'(wr_total - wb), 160'd0);
    check("t4_done_lat", 160'(done_cyc[db] - t), 160'd1);
    check("t4_err",      160'(done_err[db]), 160'd1);
    check("t4_hit_held", 160'(done_hit[db]), 160'h7);
    db = done_total;
    send(6'd1, 5'd30, 6'd1, 5'd1, 4'hD, 4'h0, 1'b0, t);
    wait_done(db); step();
    check("t4b_wr_count", 160'(wr_total - wb), 160'd0);
    check("t4b_err",      160'(done_err[db]), 160'd1);
    check("t4b_hit_held", 160'(done_hit[db]), 160'h7);

    // Reset at T+6 of a cross-row move
    wb = wr_total; db = done_total;
    send(6'd10, 5'd7, 6'd10, 5'd8, 4'hD, 4'hE, 1'b0, t);
    while (cyc < t + 6) step();
    reset = 1'b1;
    step();
    check("t5_wren_after_rst", 160'(wren), 160'd0);
    check("t5_done_after_rst", 160'(done), 160'd0);
    reset = 1'b0;
    step();
    check("t5_ready_T8", 160'(req_ready), 160'd1);
    step(); step(); step(); step();
    check("t5_wr_count", 160'(wr_total - wb), 160'd1);
    check("t5_wr_lat",   160'(wr_cyc[wb] - t), 160'd4);
    check("t5_no_done",  160'(done_total - db), 160'd0);
    check("t5_row7",     mem[7], {{10{4'h5}}, 4'hE, {29{4'h5}}});
    check("t5_row8",     mem[8], {{10{4'h6}}, 4'hB, {29{4'h6}}});

    // req_valid held high across two requests
    wb = wr_total; db = done_total; ab = acc_total;
    send(6'd5, 5'd5, 6'd6, 5'd5, 4'h2, 4'h3, 1'b1, t);
    old_x = 6'd0; old_y = 5'd5; new_x = 6'd1; new_y = 5'd5; obj_code = 4'h4; fill_code = 4'h5;
    ready_busy = req_ready;
    for (int n = 0; n < 40; n++) begin
      step();
      if (done_total > db) break;
      if (req_ready) ready_busy = 1'b1;
    end
    check("t6_ready_low_busy", 160'(ready_busy), 160'd0);
    step();
    check("t6_accepts",     160'(acc_total - ab), 160'd2);
    check("t6_second_acc",  160'(acc_cyc[ab+1] - done_cyc[db]), 160'd1);
    req_valid = 1'b0;
    wait_done(db + 1); step();
    check("t6_wr_count",  160'(wr_total - wb), 160'd2);
    check("t6_wr1_data",  wr_data[wb],
          {4'h1, 4'h1, 4'h1, 4'h0, 4'hA, 4'h3, 4'h2, {33{4'h1}}});
    check("t6_wr2_data",  wr_data[wb+1],
          {4'h5, 4'h4, 4'h1, 4'h0, 4'hA, 4'h3, 4'h2, {33{4'h1}}});
    check("t6_hit1",      160'(done_hit[db]), 160'h1);
    check("t6_hit2",      160'(done_hit[db+1]), 160'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_move_rmw.md
Name: map_move_rmw

Overview:
- Read-modify-write engine between the sprite location controllers (pacman / ghost) and port b of the map RAM.
- Takes one move request at a time: write `fill_code` into the vacated cell and `obj_code` into the destination cell.
- Preserves the other 39 cells of each 160-bit map row.
- Reports the object code found at the destination before it is overwritten; collision and pill logic consume it.

Parameters:
- RD_LAT, 2, cycles from a stable `wraddr` to valid `redata` on map RAM port b.
- COLS, 40, map cells per row; each cell is 4 bits, row word width = 4*COLS.
- ROWS, 30, map rows.

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  move request present.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- old_x  input  6  vacated cell column.
- old_y  input  5  vacated cell row.
- new_x  input  6  destination column.
- new_y  input  5  destination row.
- obj_code  input  4  code written at the destination.
- fill_code  input  4  code written at the vacated cell.
- wraddr  output  5  map RAM port b address.
- wren  output  1  map RAM port b write enable.
- wrdata  output  160  map RAM port b write data.
- redata  input  160  map RAM port b read data.
- done  output  1  one-cycle pulse when a request finishes.
- hit_code  output  4  prior destination cell content; valid with done and held until the next done.
- err  output  1  with done: the request was rejected as out of range.

Behaviour:
- Reset values: req_ready=0 during the reset cycle, 1 afterwards; wren=0, wraddr=0, wrdata=0, done=0, hit_code=0, err=0; state IDLE.
- All outputs are registered.
- Cell mapping: column x occupies row-word bits [4*(COLS-1-x)+3 : 4*(COLS-1-x)], so x=0 is the MSBs.
- States: IDLE, RD_A, WR_A, RD_B, WR_B, FIN.
- Request fields are latched on accept and inputs are ignored until the next IDLE.
- Out of range (any x>=COLS or y>=ROWS):
  - IDLE -> FIN; no read, no write.
  - FIN: done=1, err=1, hit_code unchanged.
- Single-row case (old_y==new_y), request accepted at cycle T:
  - T+1: wraddr=old_y; RD_A counts RD_LAT cycles.
  - T+1+RD_LAT: redata sampled. Both cells are merged into one word: fill_code at old_x first, then obj_code at new_x. If old_x==new_x, obj_code wins.
  - hit_code candidate = the original cell at new_x.
  - T+2+RD_LAT: WR_A, wren=1 for exactly one cycle.
  - T+3+RD_LAT: FIN, done=1, err=0. With RD_LAT=2, done at T+5.
- Two-row case (old_y!=new_y):
  - Phase A runs as above on old_y, writing fill_code only.
  - WR_A -> RD_B: wraddr=new_y; wait RD_LAT; sample; obj_code merged at new_x; hit_code captured.
  - WR_B: one-cycle write.
  - FIN: done pulse at T+2*RD_LAT+5 (T+9 with defaults).
  - The row B read always starts after the row A write, so there is no read-before-write hazard.
- wraddr is held stable from the start of each RD state through its WR cycle.
- wrdata is valid whenever wren=1; otherwise it holds its last value.
- FIN -> IDLE on the next cycle. req_ready returns to 1 the cycle after done, so back-to-back requests are spaced at least (done cycle + 1).
- Exactly 0, 1 or 2 write pulses per request; never a write to any row other than old_y / new_y.
- Reset mid-operation:
  - Next cycle: state IDLE, wren=0, no further reads or writes, no done pulse.
  - A write already pulsed stays in RAM; the partial move is not rolled back.
- req_valid while busy: ignored (req_ready=0); the upstream block must hold it.

Test Plan:
- Same-row move, preload row 5 = all 0x1. Request old=(3,5), new=(4,5), obj=0xA, fill=0x0.
  - Exactly one wren, at T+4, with wraddr=5.
  - wrdata has cell3=0x0, cell4=0xA, others 0x1.
  - done at T+5, hit_code=0x1, err=0.
- Cross-row move, row 7 cell 10 = 0x2, row 8 cell 10 = 0x3. Request old=(10,7), new=(10,8), obj=0xB, fill=0x0.
  - First wren at T+4 on addr 7 (cell10=0x0), second wren at T+8 on addr 8 (cell10=0xB).
  - done at T+9, hit_code=0x3.
- Same-cell request old=new=(0,0), obj=0xC.
  - One write; cell0 (bits 159:156) = 0xC, others unchanged.
  - hit_code = prior cell0 value.
- Out-of-range: new_x=40.
  - No wren; done with err=1 at T+1 after accept.
  - hit_code keeps its previous value.
- Reset asserted at T+6 of a cross-row move.
  - Row 7 already written.
  - No wren after T+6, no done pulse, req_ready=1 at T+8.
- req_valid held high continuously: the second request is accepted only at the cycle after the first done; req_ready=0 throughout the busy period.
